speedsensor_axil_slave: RTL and testbench

- AXI4-Lite responder for the SpeedSensor IP. It is the slave end of the S00_AXI interface that the AXI VIP master drives with single-beat AXI4LITE_WRITE_BURST and AXI4LITE_READ_BURST calls.
- Holds the control and configuration registers and measures pulse rate on a sensor input over a programmable gate window.
- Exposes the latched count read-only.

---
 rtl/speedsensor_pkg.sv | 35 +++
 rtl/speedsensor_gate_counter.sv | 76 +++++++
 rtl/speedsensor_axil_slave.sv | 219 +++++++++++++++++++++
 tb/tb_speedsensor_axil_slave.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speedsensor_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | speedsensor_pkg : register map, response codes and AXI FSM states      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package speedsensor_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_GATE     = 3'd1;
  localparam logic [2:0] REG_SCRATCH  = 3'd2;
  localparam logic [2:0] REG_IRQ_MASK = 3'd3;
  localparam logic [2:0] REG_SPEED    = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;

  typedef enum logic [0:0] { W_IDLE = 1'b0, W_RESP = 1'b1 } wr_state_e;
  typedef enum logic [0:0] { R_IDLE = 1'b0, R_DATA = 1'b1 } rd_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/speedsensor_gate_counter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | speedsensor_gate_counter : sensor sync, edge count over a gate window   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module speedsensor_gate_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sensor_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 restart_i,
  input  logic                 status_w1c_i,
  input  logic [CNT_WIDTH-1:0] gate_len_i,
  output logic [CNT_WIDTH-1:0] speed_o,
  output logic                 valid_o
);

  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_WIDTH-1:0] gate_cnt_q, edge_cnt_q, speed_q;
  logic                 valid_q;

  logic                 w_edge, w_run, w_terminal;
  logic [CNT_WIDTH-1:0] edge_cnt_d;

  always_comb begin
    w_edge     = sync2_q & ~prev_q;
    // A GATE write restarts the window, so no terminal cycle on that edge
    w_run      = enable_i && (gate_len_i != '0) && !restart_i;
    w_terminal = w_run && (gate_cnt_q == gate_len_i - CNT_WIDTH'(1));
    edge_cnt_d = (edge_cnt_q == '1) ? edge_cnt_q : edge_cnt_q + CNT_WIDTH'(w_edge);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      speed_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clear_i) begin
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
        speed_q    <= '0;
        valid_q    <= 1'b0;
      end else begin
        if (!w_run) begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
        end else if (w_terminal) begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          speed_q    <= edge_cnt_d;
        end else begin
          gate_cnt_q <= gate_cnt_q + CNT_WIDTH'(1);
          edge_cnt_q <= edge_cnt_d;
        end
        if (w_terminal)        valid_q <= 1'b1;
        else if (status_w1c_i) valid_q <= 1'b0;
      end
    end
  end

  assign speed_o = speed_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/speedsensor_axil_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | speedsensor_axil_slave : AXI4-Lite register slave for the SpeedSensor   |
// | Optional irq output when SPEEDSENSOR_IRQ_EN is defined.   Rev 1.0       |
// +-------------------------------------------------------------------------+
module speedsensor_axil_slave
  import speedsensor_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            sensor_in
`ifdef SPEEDSENSOR_IRQ_EN
  ,
  output logic                            irq
`endif
);

  wr_state_e   wr_state_q;
  logic        awready_q, wready_q, bvalid_q, aw_held_q, w_held_q;
  logic [2:0]  awidx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  rd_state_e   rd_state_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;

  logic        enable_q;
  logic [31:0] gate_q, scratch_q, irq_mask_q;

  logic                 w_aw_hs, w_w_hs, w_do_write;
  logic [2:0]           w_wr_idx;
  logic [31:0]          w_wr_data, w_rd_word;
  logic [3:0]           w_wr_strb;
  logic                 w_clear, w_restart, w_w1c, w_valid;
  logic [CNT_WIDTH-1:0] w_speed;
  logic                 w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Take address/data from the holding registers once their half has been accepted
  always_comb begin
    w_aw_hs    = s00_axi_awvalid & awready_q;
    w_w_hs     = s00_axi_wvalid & wready_q;
    w_do_write = (wr_state_q == W_IDLE) && (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);
    w_wr_idx   = aw_held_q ? awidx_q : s00_axi_awaddr[4:2];
    w_wr_data  = w_held_q ? wdata_q : s00_axi_wdata;
    w_wr_strb  = w_held_q ? wstrb_q : s00_axi_wstrb;
    w_clear    = w_do_write && (w_wr_idx == REG_CTRL) && w_wr_strb[0] && w_wr_data[CTRL_CLEAR_BIT];
    w_restart  = w_do_write && (w_wr_idx == REG_GATE) && (w_wr_strb != 4'b0000);
    w_w1c      = w_do_write && (w_wr_idx == REG_STATUS) && w_wr_strb[0] && w_wr_data[0];
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (w_do_write) begin
            wr_state_q <= W_RESP;
            bvalid_q   <= 1'b1;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
          end else begin
            if (w_aw_hs) begin
              aw_held_q <= 1'b1;
              awidx_q   <= s00_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= s00_axi_wdata;
              wstrb_q  <= s00_axi_wstrb;
            end
            awready_q <= !(aw_held_q || w_aw_hs);
            wready_q  <= !(w_held_q || w_w_hs);
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      enable_q   <= 1'b0;
      gate_q     <= '0;
      scratch_q  <= '0;
      irq_mask_q <= '0;
    end else if (w_do_write) begin
      case (w_wr_idx)
        REG_CTRL:     if (w_wr_strb[0]) enable_q <= w_wr_data[CTRL_ENABLE_BIT];
        REG_GATE:     gate_q     <= apply_wstrb(gate_q, w_wr_data, w_wr_strb);
        REG_SCRATCH:  scratch_q  <= apply_wstrb(scratch_q, w_wr_data, w_wr_strb);
        REG_IRQ_MASK: irq_mask_q <= apply_wstrb(irq_mask_q, w_wr_data, w_wr_strb);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_word = '0;
    case (s00_axi_araddr[4:2])
      REG_CTRL:     w_rd_word = {31'b0, enable_q};
      REG_GATE:     w_rd_word = gate_q;
      REG_SCRATCH:  w_rd_word = scratch_q;
      REG_IRQ_MASK: w_rd_word = irq_mask_q;
      REG_SPEED:    w_rd_word = 32'(w_speed);
      REG_STATUS:   w_rd_word = {31'b0, w_valid};
      default:      w_rd_word = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (s00_axi_arvalid && arready_q) begin
            rd_state_q <= R_DATA;
            rdata_q    <= w_rd_word;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  speedsensor_gate_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_gate_counter (
    .clk_i        (s00_axi_aclk),
    .rst_i        (s00_axi_areset),
    .sensor_i     (sensor_in),
    .enable_i     (enable_q),
    .clear_i      (w_clear),
    .restart_i    (w_restart),
    .status_w1c_i (w_w1c),
    .gate_len_i   (gate_q[CNT_WIDTH-1:0]),
    .speed_o      (w_speed),
    .valid_o      (w_valid)
  );

`ifdef SPEEDSENSOR_IRQ_EN
  logic irq_q;
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) irq_q <= 1'b0;
    else                irq_q <= w_valid & irq_mask_q[0];
  end
  assign irq = irq_q;
`endif

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_speedsensor_axil_slave.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_speedsensor_axil_slave : randomized self-checking bench              |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_speedsensor_axil_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        sensor = 1'b0;
`ifdef SPEEDSENSOR_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: plain register image plus measured result
  logic [31:0] m_reg [8];
  logic [31:0] m_speed;
  logic        m_valid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  speedsensor_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .sensor_in       (sensor)
`ifdef SPEEDSENSOR_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_speed = '0;
    m_valid = 1'b0;
  endfunction

  function automatic void model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    case (idx)
      3'd0: begin
        if (s[0]) m_reg[0] = {31'b0, d[0]};
        if (s[0] && d[1]) begin m_speed = '0; m_valid = 1'b0; end
      end
      3'd1, 3'd2, 3'd3:
        for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
      3'd5: if (s[0] && d[0]) m_valid = 1'b0;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: return m_reg[idx];
      3'd4:    return m_speed;
      3'd5:    return {31'b0, m_valid};
      default: return '0;
    endcase
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit skip_b, output logic [1:0] resp);
    bit aw_done, w_done, aw_f, w_f;
    int k;
    aw_done = 0; w_done = 0; k = 0; resp = 2'bxx;
    @(posedge clk); #1;
    awaddr = a; awprot = 3'($urandom); wdata = d; wstrb = s;
    while (!(aw_done && w_done) && k < 100) begin
      if (!aw_done && k >= aw_dly) awvalid = 1'b1;
      if (!w_done && k >= w_dly) wvalid = 1'b1;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
      if (w_f)  begin wvalid = 1'b0;  w_done = 1;  end
      k++;
    end
    if (!(aw_done && w_done)) begin
      n_vec++; n_err++;
      $display("FAIL wr_addr_data_timeout: aw_done=%0d w_done=%0d required 1 1", aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    k = 0;
    while (!bvalid && k < 100) begin @(posedge clk); #1; k++; end
    if (!bvalid) begin
      n_vec++; n_err++;
      $display("FAIL wr_bvalid_timeout: bvalid=%0b required 1", bvalid);
      return;
    end
    resp = bresp;
    if (skip_b) return;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int hold, output logic [31:0] data,
                          output logic [1:0] resp, output bit stable);
    int k;
    data = 'x; resp = 2'bxx; stable = 1;
    @(posedge clk); #1;
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1; k = 0;
    while (!arready && k < 100) begin @(posedge clk); #1; k++; end
    if (!arready) begin
      n_vec++; n_err++;
      $display("FAIL rd_arready_timeout: arready=%0b required 1", arready);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0; k = 0;
    while (!rvalid && k < 100) begin @(posedge clk); #1; k++; end
    if (!rvalid) begin
      n_vec++; n_err++;
      $display("FAIL rd_rvalid_timeout: rvalid=%0b required 1", rvalid);
      return;
    end
    data = rdata; resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rvalid || rdata !== data || arready) stable = 0;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic drive_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sensor = 1'b1; repeat (2) @(posedge clk); #1;
      sensor = 1'b0; repeat (3) @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: aw%0b w%0b b%0b ar%0b r%0b rdata=%h required all 0",
               awready, wready, bvalid, arready, rvalid, rdata);
    end
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_regs();
    logic [1:0] resp; logic [31:0] rd, d; logic [3:0] s; logic [2:0] idx; bit st;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, resp);
      model_write(3'(i), 32'(i + 1), 4'hF);
      n_vec++;
      if (resp !== 2'b00) begin n_err++; $display("FAIL regs_bresp: got %b required 00", resp); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), 0, rd, resp, st);
      n_vec++;
      if (rd !== model_read(3'(i)) || resp !== 2'b00) begin
        n_err++;
        $display("FAIL regs_readback[%0d]: got %h/%b required %h/00", i, rd, resp, model_read(3'(i)));
      end
    end
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp);
    model_write(3'd0, 32'h2, 4'hF);
    for (int i = 0; i < 12; i++) begin
      do idx = 3'($urandom_range(0, 7)); while (idx == 3'd5);
      d = $urandom; s = 4'($urandom);
      axi_write({idx, 2'b00}, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 0, resp);
      model_write(idx, d, s);
      n_vec++;
      if (resp !== 2'b00) begin n_err++; $display("FAIL rand_bresp: got %b required 00", resp); end
      do idx = 3'($urandom_range(0, 7)); while (idx == 3'd5);
      axi_read({idx, 2'b00}, 0, rd, resp, st);
      n_vec++;
      if (rd !== model_read(idx)) begin
        n_err++;
        $display("FAIL rand_read[%0d]: got %h required %h", idx, rd, model_read(idx));
      end
    end
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp);
    model_write(3'd0, 32'h2, 4'hF);
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] rd; bit st, extra;
    axi_write(5'h08, 32'h0, 4'hF, 0, 0, 0, resp);
    model_write(3'd2, 32'h0, 4'hF);
    axi_write(5'h08, 32'hA5A5A5A5, 4'b0011, 3, 0, 0, resp);
    model_write(3'd2, 32'hA5A5A5A5, 4'b0011);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (bvalid) extra = 1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (extra || resp !== 2'b00) begin
      n_err++; $display("FAIL w_first_bvalid_once: extra=%0b resp=%b required 0/00", extra, resp);
    end
    axi_read(5'h08, 0, rd, resp, st);
    n_vec++;
    if (rd !== model_read(3'd2)) begin
      n_err++; $display("FAIL w_first_scratch: got %h required %h", rd, model_read(3'd2));
    end
  endtask

  task automatic test_speed();
    logic [1:0] resp; logic [31:0] rd; bit st;
    int g, np, t0;
    for (int it = 0; it < 3; it++) begin
      g  = (it == 0) ? 100 : $urandom_range(80, 120);
      np = (it == 0) ? 7 : $urandom_range(1, 10);
      axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h2, 4'hF);
      axi_write(5'h04, 32'(g), 4'hF, 0, 0, 0, resp); model_write(3'd1, 32'(g), 4'hF);
      axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h1, 4'hF);
      t0 = cyc;
      repeat (10) @(posedge clk); #1;
      drive_pulses(np);
      while (cyc < t0 + g + 6) begin @(posedge clk); #1; end
      m_speed = 32'(np); m_valid = 1'b1;
      axi_read(5'h10, 0, rd, resp, st);
      n_vec++;
      if (rd !== m_speed) begin n_err++; $display("FAIL speed_count[%0d]: got %0d required %0d", it, rd, m_speed); end
      axi_read(5'h14, 0, rd, resp, st);
      n_vec++;
      if (rd !== model_read(3'd5)) begin n_err++; $display("FAIL status_valid[%0d]: got %h required %h", it, rd, model_read(3'd5)); end
      axi_write(5'h14, 32'h1, 4'hF, 0, 0, 0, resp); model_write(3'd5, 32'h1, 4'hF);
      axi_read(5'h14, 0, rd, resp, st);
      n_vec++;
      if (rd !== model_read(3'd5)) begin n_err++; $display("FAIL status_w1c[%0d]: got %h required %h", it, rd, model_read(3'd5)); end
      axi_write(5'h00, 32'h0, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h0, 4'hF);
      repeat (g + 10) @(posedge clk); #1;
      axi_read(5'h10, 0, rd, resp, st);
      n_vec++;
      if (rd !== m_speed) begin n_err++; $display("FAIL speed_retained[%0d]: got %0d required %0d", it, rd, m_speed); end
    end
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h2, 4'hF);
    axi_read(5'h10, 0, rd, resp, st);
    n_vec++;
    if (rd !== m_speed) begin n_err++; $display("FAIL speed_clear: got %h required %h", rd, m_speed); end
  endtask

  task automatic test_gate_zero();
    logic [1:0] resp; logic [31:0] rd; bit st;
    axi_write(5'h04, 32'h0, 4'hF, 0, 0, 0, resp); model_write(3'd1, 32'h0, 4'hF);
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h1, 4'hF);
    drive_pulses(5);
    repeat (20) @(posedge clk); #1;
    axi_read(5'h14, 0, rd, resp, st);
    n_vec++;
    if (rd !== model_read(3'd5)) begin n_err++; $display("FAIL gate_zero_status: got %h required %h", rd, model_read(3'd5)); end
    axi_read(5'h10, 0, rd, resp, st);
    n_vec++;
    if (rd !== m_speed) begin n_err++; $display("FAIL gate_zero_speed: got %h required %h", rd, m_speed); end
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h2, 4'hF);
  endtask

  task automatic test_read_stall();
    logic [1:0] resp; logic [31:0] rd, d; bit st;
    axi_read(5'h10, 5, rd, resp, st);
    n_vec++;
    if (!st || rd !== m_speed || resp !== 2'b00) begin
      n_err++; $display("FAIL stall_speed: stable=%0b data=%h resp=%b required 1/%h/00", st, rd, resp, m_speed);
    end
    d = $urandom;
    axi_write(5'h08, d, 4'hF, 0, 0, 0, resp); model_write(3'd2, d, 4'hF);
    axi_read(5'h08, 5, rd, resp, st);
    n_vec++;
    if (!st || rd !== model_read(3'd2)) begin
      n_err++; $display("FAIL stall_scratch: stable=%0b data=%h required 1/%h", st, rd, model_read(3'd2));
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] wresp, rresp_l; logic [31:0] rd, d, exp_gate; bit st;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      exp_gate = model_read(3'd1);
      fork
        axi_write(5'h08, d, 4'hF, 0, 0, 0, wresp);
        axi_read(5'h04, 0, rd, rresp_l, st);
      join
      model_write(3'd2, d, 4'hF);
      n_vec++;
      if (rd !== exp_gate || wresp !== 2'b00 || rresp_l !== 2'b00) begin
        n_err++; $display("FAIL concurrent[%0d]: rd=%h b=%b r=%b required %h/00/00", i, rd, wresp, rresp_l, exp_gate);
      end
      axi_read(5'h08, 0, rd, rresp_l, st);
      n_vec++;
      if (rd !== model_read(3'd2)) begin
        n_err++; $display("FAIL concurrent_scratch[%0d]: got %h required %h", i, rd, model_read(3'd2));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] rd; bit st;
    axi_write(5'h0C, $urandom, 4'hF, 0, 0, 1, resp);
    n_vec++;
    if (bvalid !== 1'b1) begin n_err++; $display("FAIL rst_mid_pending: bvalid=%0b required 1", bvalid); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_drop: bvalid=%0b awready=%0b required 0 0", bvalid, awready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      axi_read(5'(i * 4), 0, rd, resp, st);
      n_vec++;
      if (rd !== model_read(3'(i))) begin
        n_err++; $display("FAIL rst_mid_reg[%0d]: got %h required %h", i, rd, model_read(3'(i)));
      end
    end
  endtask

`ifdef SPEEDSENSOR_IRQ_EN
  task automatic test_irq();
    logic [1:0] resp; int k;
    axi_write(5'h0C, 32'h1, 4'hF, 0, 0, 0, resp); model_write(3'd3, 32'h1, 4'hF);
    axi_write(5'h04, 32'd60, 4'hF, 0, 0, 0, resp); model_write(3'd1, 32'd60, 4'hF);
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h1, 4'hF);
    k = 0;
    while (irq !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %0b required 1", irq); end
    axi_write(5'h14, 32'h1, 4'hF, 0, 0, 0, resp); model_write(3'd5, 32'h1, 4'hF);
    @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %0b required 0", irq); end
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp); model_write(3'd0, 32'h2, 4'hF);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_regs();
    test_w_before_aw();
    test_speed();
    test_gate_zero();
    test_read_stall();
    test_back_to_back();
`ifdef SPEEDSENSOR_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
